// File: rtl/text_char_buffer.sv
`default_nettype none
// ============================================================================
// Module   : text_char_buffer
// Brief    : COLS x ROWS character-cell text buffer for the 720p overlay.
//            A byte-stream terminal port (cursor, newline, backspace, clear)
//            writes the cell RAM.  A 3-stage pixel pipeline turns the raster
//            position into a character code plus glyph-local coordinates for
//            the font ROM, and carries de/hsync/vsync alongside.
// Revision : 1.0 - initial release
// ============================================================================
module text_char_buffer #(
    parameter int COLS             = 160,
    parameter int ROWS             = 45,
    parameter int HORIZONTAL_WIDTH = 1650,
    parameter int VERTICAL_WIDTH   = 750
) (
    input  logic                                i_clk,
    input  logic                                i_rst_n,
    input  logic [$clog2(HORIZONTAL_WIDTH)-1:0] i_sx,
    input  logic [$clog2(VERTICAL_WIDTH)-1:0]   i_sy,
    input  logic                                i_de,
    input  logic                                i_hsync,
    input  logic                                i_vsync,
    input  logic                                i_wr_valid,
    input  logic [7:0]                          i_wr_data,
    output logic                                o_wr_ready,
    output logic [7:0]                          o_character,
    output logic [2:0]                          o_glyph_x,
    output logic [3:0]                          o_glyph_y,
    output logic                                o_en,
    output logic                                o_de,
    output logic                                o_hsync,
    output logic                                o_vsync,
    output logic [$clog2(COLS)-1:0]             o_cursor_col,
    output logic [$clog2(ROWS)-1:0]             o_cursor_row
);

    localparam int c_SX_W   = $clog2(HORIZONTAL_WIDTH);
    localparam int c_SY_W   = $clog2(VERTICAL_WIDTH);
    localparam int c_COL_W  = $clog2(COLS);
    localparam int c_ROW_W  = $clog2(ROWS);
    localparam int c_CELLS  = COLS * ROWS;
    localparam int c_ADDR_W = $clog2(c_CELLS);

    localparam logic [c_ADDR_W-1:0] c_LAST_ADDR = c_ADDR_W'(c_CELLS - 1);
    localparam logic [c_COL_W-1:0]  c_LAST_COL  = c_COL_W'(COLS - 1);
    localparam logic [c_ROW_W-1:0]  c_LAST_ROW  = c_ROW_W'(ROWS - 1);
    localparam logic [c_SX_W-1:0]   c_TEXT_W    = c_SX_W'(COLS * 8);
    localparam logic [c_SY_W-1:0]   c_TEXT_H    = c_SY_W'(ROWS * 16);
    localparam logic [7:0]          c_SPACE     = 8'h20;
    localparam logic [7:0]          c_LF        = 8'h0A;
    localparam logic [7:0]          c_CR        = 8'h0D;
    localparam logic [7:0]          c_BS        = 8'h08;
    localparam logic [7:0]          c_FF        = 8'h0C;

    typedef enum logic [0:0] {
        S_CLEAR = 1'b0,
        S_IDLE  = 1'b1
    } state_t;

    // ------------------------------------------------------------------------
    // Write side
    // ------------------------------------------------------------------------
    state_t                r_state;
    logic [c_ADDR_W-1:0]   r_clr_addr;
    logic [c_COL_W-1:0]    r_cur_col;
    logic [c_ROW_W-1:0]    r_cur_row;
    logic                  r_wr_ready;

    logic                  w_accept;
    logic                  w_printable;
    logic [c_ROW_W-1:0]    w_row_inc;
    logic [c_ADDR_W-1:0]   w_cur_addr;
    logic                  w_ram_we;
    logic [c_ADDR_W-1:0]   w_ram_waddr;
    logic [7:0]            w_ram_wdata;

    // Ready is only ever high in IDLE, so it doubles as the state qualifier.
    assign w_accept    = i_wr_valid && r_wr_ready;
    assign w_printable = (i_wr_data >= c_SPACE);
    assign w_row_inc   = (r_cur_row == c_LAST_ROW) ? '0 : r_cur_row + 1'b1;
    assign w_cur_addr  = c_ADDR_W'(r_cur_row * COLS) + c_ADDR_W'(r_cur_col);

    // Select the RAM write source: clear sweep or an accepted printable byte.
    always_comb begin
        w_ram_we    = 1'b0;
        w_ram_waddr = r_clr_addr;
        w_ram_wdata = c_SPACE;
        if (r_state == S_CLEAR) begin
            w_ram_we = 1'b1;
        end else if (w_accept && w_printable) begin
            w_ram_we    = 1'b1;
            w_ram_waddr = w_cur_addr;
            w_ram_wdata = i_wr_data;
        end
    end

    // Write FSM: screen clear sweep, then byte acceptance with cursor update.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_CLEAR;
            r_clr_addr <= '0;
            r_cur_col  <= '0;
            r_cur_row  <= '0;
            r_wr_ready <= 1'b0;
        end else begin
            case (r_state)
                S_CLEAR: begin
                    if (r_clr_addr == c_LAST_ADDR) begin
                        r_state    <= S_IDLE;
                        r_wr_ready <= 1'b1;
                        r_clr_addr <= '0;
                    end else begin
                        r_clr_addr <= r_clr_addr + 1'b1;
                    end
                end
                S_IDLE: begin
                    if (w_accept) begin
                        if (w_printable) begin
                            if (r_cur_col == c_LAST_COL) begin
                                r_cur_col <= '0;
                                r_cur_row <= w_row_inc;
                            end else begin
                                r_cur_col <= r_cur_col + 1'b1;
                            end
                        end else begin
                            case (i_wr_data)
                                c_LF: begin
                                    r_cur_col <= '0;
                                    r_cur_row <= w_row_inc;
                                end
                                c_CR: r_cur_col <= '0;
                                c_BS: begin
                                    if (r_cur_col != '0) begin
                                        r_cur_col <= r_cur_col - 1'b1;
                                    end
                                end
                                c_FF: begin
                                    r_cur_col  <= '0;
                                    r_cur_row  <= '0;
                                    r_clr_addr <= '0;
                                    r_wr_ready <= 1'b0;
                                    r_state    <= S_CLEAR;
                                end
                                default: ;
                            endcase
                        end
                    end
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Cell RAM (simple dual port, read-first, contents not reset)
    // ------------------------------------------------------------------------
    logic [7:0]          r_mem [0:c_CELLS-1];
    logic [7:0]          r_rd_data;
    logic [c_ADDR_W-1:0] r_s1_addr;

    // Write port owned by the write FSM.
    always_ff @(posedge i_clk) begin
        if (w_ram_we) begin
            r_mem[w_ram_waddr] <= w_ram_wdata;
        end
    end

    // Read port owned by the pixel pipeline; a same-edge write returns old data.
    always_ff @(posedge i_clk) begin
        r_rd_data <= r_mem[r_s1_addr];
    end

    // ------------------------------------------------------------------------
    // Pixel pipeline
    // ------------------------------------------------------------------------
    logic                w_in_area;
    logic [c_ADDR_W-1:0] w_pix_addr;

    logic       r_s1_in_area, r_s1_de, r_s1_hs, r_s1_vs;
    logic [2:0] r_s1_gx;
    logic [3:0] r_s1_gy;
    logic       r_s2_in_area, r_s2_de, r_s2_hs, r_s2_vs;
    logic [2:0] r_s2_gx;
    logic [3:0] r_s2_gy;

    logic [7:0] r_character;
    logic [2:0] r_glyph_x;
    logic [3:0] r_glyph_y;
    logic       r_en, r_de, r_hs, r_vs;

    // Out-of-area positions park the address at 0 so it never exceeds the RAM.
    assign w_in_area  = (i_sx < c_TEXT_W) && (i_sy < c_TEXT_H);
    assign w_pix_addr = w_in_area
                      ? c_ADDR_W'(i_sy[c_SY_W-1:4] * COLS) + c_ADDR_W'(i_sx[c_SX_W-1:3])
                      : '0;

    // Stages 1-3: address/side-signal capture, RAM read alignment, output register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1_addr    <= '0;
            r_s1_in_area <= 1'b0;
            r_s1_gx      <= '0;
            r_s1_gy      <= '0;
            r_s1_de      <= 1'b0;
            r_s1_hs      <= 1'b0;
            r_s1_vs      <= 1'b0;
            r_s2_in_area <= 1'b0;
            r_s2_gx      <= '0;
            r_s2_gy      <= '0;
            r_s2_de      <= 1'b0;
            r_s2_hs      <= 1'b0;
            r_s2_vs      <= 1'b0;
            r_character  <= 8'h00;
            r_glyph_x    <= '0;
            r_glyph_y    <= '0;
            r_en         <= 1'b0;
            r_de         <= 1'b0;
            r_hs         <= 1'b0;
            r_vs         <= 1'b0;
        end else begin
            r_s1_addr    <= w_pix_addr;
            r_s1_in_area <= w_in_area;
            r_s1_gx      <= i_sx[2:0];
            r_s1_gy      <= i_sy[3:0];
            r_s1_de      <= i_de;
            r_s1_hs      <= i_hsync;
            r_s1_vs      <= i_vsync;

            r_s2_in_area <= r_s1_in_area;
            r_s2_gx      <= r_s1_gx;
            r_s2_gy      <= r_s1_gy;
            r_s2_de      <= r_s1_de;
            r_s2_hs      <= r_s1_hs;
            r_s2_vs      <= r_s1_vs;

            r_character  <= r_s2_in_area ? r_rd_data : c_SPACE;
            r_glyph_x    <= r_s2_gx;
            r_glyph_y    <= r_s2_gy;
            r_en         <= r_s2_in_area && r_s2_de;
            r_de         <= r_s2_de;
            r_hs         <= r_s2_hs;
            r_vs         <= r_s2_vs;
        end
    end

    assign o_wr_ready   = r_wr_ready;
    assign o_cursor_col = r_cur_col;
    assign o_cursor_row = r_cur_row;
    assign o_character  = r_character;
    assign o_glyph_x    = r_glyph_x;
    assign o_glyph_y    = r_glyph_y;
    assign o_en         = r_en;
    assign o_de         = r_de;
    assign o_hsync      = r_hs;
    assign o_vsync      = r_vs;

endmodule
`default_nettype wire

// File: tb/tb_text_char_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_text_char_buffer
// Brief    : Self-checking bench for text_char_buffer: a cell-array/cursor
//            model checked every cycle, plus hand-computed literal checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_text_char_buffer;

    localparam int COLS  = 160;
    localparam int ROWS  = 45;
    localparam int CELLS = COLS * ROWS;
    localparam int SX_W  = $clog2(1650);
    localparam int SY_W  = $clog2(750);
    localparam int CC_W  = $clog2(COLS);
    localparam int CR_W  = $clog2(ROWS);

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [SX_W-1:0] sx = '0;
    logic [SY_W-1:0] sy = '0;
    logic            de = 1'b0, hs = 1'b0, vs = 1'b0;
    logic            wr_valid = 1'b0;
    logic [7:0]      wr_data = 8'h00;
    logic            wr_ready;
    logic [7:0]      character;
    logic [2:0]      gx;
    logic [3:0]      gy;
    logic            en, ode, ohs, ovs;
    logic [CC_W-1:0] ccol;
    logic [CR_W-1:0] crow;

    always #5 clk = ~clk;

    text_char_buffer dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_sx         (sx),
        .i_sy         (sy),
        .i_de         (de),
        .i_hsync      (hs),
        .i_vsync      (vs),
        .i_wr_valid   (wr_valid),
        .i_wr_data    (wr_data),
        .o_wr_ready   (wr_ready),
        .o_character  (character),
        .o_glyph_x    (gx),
        .o_glyph_y    (gy),
        .o_en         (en),
        .o_de         (ode),
        .o_hsync      (ohs),
        .o_vsync      (ovs),
        .o_cursor_col (ccol),
        .o_cursor_row (crow)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        bit         v;
        bit         known;
        logic [7:0] ch;
        int         gx;
        int         gy;
        bit         en;
        bit         de;
        bit         hs;
        bit         vs;
    } pix_t;

    logic [7:0] m_mem   [CELLS];
    bit         m_known [CELLS];
    int         m_col, m_row, m_clear_left;
    bit         m_acc;
    pix_t       m_pipe  [3];
    pix_t       m_p;

    task automatic model_byte(input logic [7:0] b);
        if (b >= 8'h20) begin
            m_mem[m_row * COLS + m_col]   = b;
            m_known[m_row * COLS + m_col] = 1'b1;
            m_col++;
            if (m_col == COLS) begin
                m_col = 0;
                m_row = (m_row + 1) % ROWS;
            end
        end else if (b == 8'h0A) begin
            m_col = 0;
            m_row = (m_row + 1) % ROWS;
        end else if (b == 8'h0D) begin
            m_col = 0;
        end else if (b == 8'h08) begin
            if (m_col > 0) m_col--;
        end else if (b == 8'h0C) begin
            m_col = 0;
            m_row = 0;
            m_clear_left = CELLS;
        end
    endtask

    task automatic model_reset();
        m_col = 0;
        m_row = 0;
        m_clear_left = CELLS;
        for (int i = 0; i < 3; i++) m_pipe[i].v = 1'b0;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                model_reset();
            end else begin
                // write side: a cell written at this edge is seen by a read issued at this edge
                if (m_clear_left > 0) begin
                    m_mem[CELLS - m_clear_left]   = 8'h20;
                    m_known[CELLS - m_clear_left] = 1'b1;
                    m_clear_left--;
                end else if (wr_valid) begin
                    m_acc = 1'b1;
                    model_byte(wr_data);
                end
                // pixel side
                m_p.v  = 1'b1;
                m_p.gx = int'(sx) % 8;
                m_p.gy = int'(sy) % 16;
                m_p.de = de;
                m_p.hs = hs;
                m_p.vs = vs;
                if (int'(sx) < COLS * 8 && int'(sy) < ROWS * 16) begin
                    m_p.known = m_known[(int'(sy) / 16) * COLS + int'(sx) / 8];
                    m_p.ch    = m_mem[(int'(sy) / 16) * COLS + int'(sx) / 8];
                    m_p.en    = de;
                end else begin
                    m_p.known = 1'b1;
                    m_p.ch    = 8'h20;
                    m_p.en    = 1'b0;
                end
                m_pipe[2] = m_pipe[1];
                m_pipe[1] = m_pipe[0];
                m_pipe[0] = m_p;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                check("rst_character", 32'(character), 0);
                check("rst_glyph_x", 32'(gx), 0);
                check("rst_glyph_y", 32'(gy), 0);
                check("rst_en", 32'(en), 0);
                check("rst_de", 32'(ode), 0);
                check("rst_hsync", 32'(ohs), 0);
                check("rst_vsync", 32'(ovs), 0);
                check("rst_wr_ready", 32'(wr_ready), 0);
                check("rst_cursor_col", 32'(ccol), 0);
                check("rst_cursor_row", 32'(crow), 0);
            end else begin
                check("wr_ready", 32'(wr_ready), (m_clear_left == 0) ? 1 : 0);
                check("cursor_col", 32'(ccol), m_col);
                check("cursor_row", 32'(crow), m_row);
                if (m_pipe[2].v) begin
                    check("glyph_x", 32'(gx), m_pipe[2].gx);
                    check("glyph_y", 32'(gy), m_pipe[2].gy);
                    check("en", 32'(en), 32'(m_pipe[2].en));
                    check("de", 32'(ode), 32'(m_pipe[2].de));
                    check("hsync", 32'(ohs), 32'(m_pipe[2].hs));
                    check("vsync", 32'(ovs), 32'(m_pipe[2].vs));
                    if (m_pipe[2].known) check("character", 32'(character), 32'(m_pipe[2].ch));
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_ready(output int cnt);
        cnt = 0;
        while (!wr_ready && cnt < 8000) begin
            @(negedge clk);
            cnt++;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, output int waited);
        @(negedge clk);
        wr_valid = 1'b1;
        wr_data  = b;
        m_acc    = 1'b0;
        waited   = 0;
        while (!m_acc && waited < 20000) begin
            @(negedge clk);
            waited++;
        end
        wr_valid = 1'b0;
        if (!m_acc) check("accept_timeout", 0, 1);
    endtask

    task automatic send(input logic [7:0] b);
        int w;
        send_byte(b, w);
    endtask

    task automatic cursor_is(input string name, input int c, input int r);
        check({name, "_col"}, 32'(ccol), c);
        check({name, "_row"}, 32'(crow), r);
    endtask

    task automatic pix_check(input string name, input int x, input int y,
                             input bit d, input bit h, input bit v,
                             input int exp_ch, input int exp_en);
        @(negedge clk);
        sx = SX_W'(x);
        sy = SY_W'(y);
        de = d;
        hs = h;
        vs = v;
        repeat (3) @(negedge clk);
        check({name, "_ch"}, 32'(character), exp_ch);
        check({name, "_en"}, 32'(en), exp_en);
        check({name, "_gx"}, 32'(gx), x % 8);
        check({name, "_gy"}, 32'(gy), y % 16);
        check({name, "_de"}, 32'(ode), 32'(d));
        check({name, "_hs"}, 32'(ohs), 32'(h));
        check({name, "_vs"}, 32'(ovs), 32'(v));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int cnt;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_ready(cnt);
        check("clear_cycles_boot", cnt, 7200);
        cursor_is("boot_cursor", 0, 0);

        // one pixel per cell, glyph offsets varied, all cells must read blank
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                @(negedge clk);
                sx = SX_W'(c * 8 + c % 8);
                sy = SY_W'(r * 16 + r % 16);
                de = 1'b1;
                hs = (c % 3 == 0);
                vs = (r % 2 == 1);
            end
        end

        send(8'h41);
        cursor_is("after_A", 1, 0);
        pix_check("cell0_A", 0, 0, 1'b1, 1'b0, 1'b0, 8'h41, 1);

        for (int i = 0; i < 159; i++) send(8'h41);
        cursor_is("row_wrap", 0, 1);
        pix_check("cell159_A", 1279, 0, 1'b1, 1'b1, 1'b0, 8'h41, 1);

        for (int i = 0; i < 43; i++) send(8'h0A);
        cursor_is("at_row44", 0, 44);
        send(8'h78);
        cursor_is("row44_x", 1, 44);
        send(8'h0A);
        cursor_is("lf_wrap", 0, 0);
        pix_check("row44_x", 0, 719, 1'b1, 1'b0, 1'b1, 8'h78, 1);

        send(8'h42);
        send(8'h08);
        cursor_is("bs_first", 0, 0);
        send(8'h08);
        cursor_is("bs_at_col0", 0, 0);
        pix_check("cell0_B", 3, 2, 1'b1, 1'b0, 1'b0, 8'h42, 1);
        send(8'h44);
        cursor_is("after_D", 1, 0);
        send(8'h0D);
        cursor_is("after_cr", 0, 0);
        send(8'h07);
        cursor_is("after_bel", 0, 0);
        pix_check("cell0_D", 0, 0, 1'b1, 1'b0, 1'b0, 8'h44, 1);
        pix_check("cell1_A", 8, 0, 1'b1, 1'b0, 1'b0, 8'h41, 1);

        pix_check("outside_both", 1280, 720, 1'b1, 1'b1, 1'b0, 8'h20, 0);
        pix_check("outside_x", 1280, 100, 1'b0, 1'b0, 1'b1, 8'h20, 0);
        pix_check("outside_y", 100, 720, 1'b1, 1'b1, 1'b1, 8'h20, 0);
        pix_check("last_cell", 1279, 719, 1'b1, 1'b0, 1'b1, 8'h20, 1);
        pix_check("de_low", 0, 0, 1'b0, 1'b1, 1'b1, 8'h44, 0);

        // clear with a byte held behind it
        send(8'h0C);
        check("ff_ready_drop", 32'(wr_ready), 0);
        send_byte(8'h43, cnt);
        check("held_byte_wait", cnt, 7200);
        cursor_is("after_held_C", 1, 0);
        pix_check("cell0_C", 0, 0, 1'b1, 1'b0, 1'b0, 8'h43, 1);
        pix_check("cell1_blank", 8, 0, 1'b1, 1'b0, 1'b0, 8'h20, 1);

        // async reset while idle with a non-zero cursor and active outputs
        @(negedge clk);
        sx = SX_W'(13);
        sy = SY_W'(7);
        de = 1'b1;
        hs = 1'b1;
        vs = 1'b1;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_character", 32'(character), 0);
        check("async_rst_glyph_x", 32'(gx), 0);
        check("async_rst_glyph_y", 32'(gy), 0);
        check("async_rst_en", 32'(en), 0);
        check("async_rst_de", 32'(ode), 0);
        check("async_rst_cursor_col", 32'(ccol), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_ready(cnt);
        check("clear_cycles_rst1", cnt, 7200);

        // reset 100 cycles into a clear: the sweep must restart from zero
        send(8'h0C);
        repeat (100) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midclr_rst_character", 32'(character), 0);
        check("midclr_rst_en", 32'(en), 0);
        check("midclr_rst_hsync", 32'(ohs), 0);
        check("midclr_rst_vsync", 32'(ovs), 0);
        check("midclr_rst_wr_ready", 32'(wr_ready), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_ready(cnt);
        check("clear_cycles_rst2", cnt, 7200);
        pix_check("final_cell0", 0, 0, 1'b1, 1'b0, 1'b0, 8'h20, 1);
        cursor_is("final_cursor", 0, 0);

        repeat (4) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // watchdog
    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/text_char_buffer.md
# text_char_buffer

Character-cell text buffer sitting directly upstream of the font glyph ROM in the 720p text overlay pipeline. Holds a COLS x ROWS grid of 8-bit character codes written through a byte-stream terminal interface with cursor, newline, backspace and clear handling. On the video side it converts the current raster position into a character code plus glyph-local pixel coordinates for the font ROM. It delays de/hsync/vsync so they stay aligned with its outputs.

## Interface
- COLS, 160, character columns (8-pixel-wide cells)
- ROWS, 45, character rows (16-pixel-tall cells)
- HORIZONTAL_WIDTH, 1650, total horizontal pixels; sx width = $clog2(HORIZONTAL_WIDTH)
- VERTICAL_WIDTH, 750, total lines; sy width = $clog2(VERTICAL_WIDTH)
- i_clk  in  1  pixel clock; the only clock
- i_rst_n  in  1  asynchronous, active-low reset
- i_sx  in  $clog2(HORIZONTAL_WIDTH)  raster x from video signal generator
- i_sy  in  $clog2(VERTICAL_WIDTH)  raster y
- i_de, i_hsync, i_vsync  in  1 each  video timing from generator
- i_wr_valid  in  1  write byte offered
- i_wr_data  in  8  character or control code
- o_wr_ready  out  1  buffer can accept a byte this cycle
- o_character  out  8  character code for the current cell
- o_glyph_x  out  3  pixel column inside the glyph (sx[2:0])
- o_glyph_y  out  4  pixel row inside the glyph (sy[3:0])
- o_en  out  1  raster is inside the text area
- o_de, o_hsync, o_vsync  out  1 each  inputs delayed to align with outputs
- o_cursor_col  out  $clog2(COLS)  current cursor column
- o_cursor_row  out  $clog2(ROWS)  current cursor row

## Operation
- Storage: COLS*ROWS x 8 simple dual-port RAM, inferred as block RAM; write port owned by the write FSM, read port owned by the pixel pipeline; read-first on same-address collision. RAM contents are not reset.
- Write FSM states: CLEAR, IDLE.
  - CLEAR: write 0x20 to addresses 0..COLS*ROWS-1, one per cycle; o_wr_ready=0; on last address go to IDLE. Entered on reset deassertion and on 0x0C.
  - IDLE: o_wr_ready=1; a byte is accepted when i_wr_valid && o_wr_ready.
- Accepted byte handling (cursor c=col, r=row):
  - 0x20..0xFF: write to address r*COLS+c; c+1; if c was COLS-1 then c=0, r+1; if r was ROWS-1 then r=0 (wrap, no scroll).
  - 0x0A: c=0, r+1 with the same wrap.
  - 0x0D: c=0.
  - 0x08: c-1 if c>0, else no change; no RAM write.
  - 0x0C: c=0, r=0, enter CLEAR.
  - Other codes below 0x20: ignored, cursor unchanged.
- Address arithmetic: row*COLS computed with a constant multiply; address width $clog2(COLS*ROWS).
- Pixel pipeline:
  - Stage 1: col=sx>>3, row=sy>>4; in_area = (sx < COLS*8) && (sy < ROWS*16); register addr, in_area, sx[2:0], sy[3:0], de/hs/vs.
  - Stage 2: RAM read; pass the side signals.
  - Stage 3: register outputs. o_character = RAM data if in_area, else 0x20; o_en = in_area && de.

## Timing
- Reset (i_rst_n=0, async) clears: o_character=0x00, o_glyph_x=0, o_glyph_y=0, o_en=0, o_de/o_hsync/o_vsync=0, cursor=0,0, o_wr_ready=0.
- Write FSM state during reset is CLEAR with address 0.
- First clear write happens on the first rising edge after deassertion.
- A clear takes exactly COLS*ROWS cycles. o_wr_ready rises the cycle after the last clear write (7200 cycles at defaults).
- Pixel latency: i_sx/i_sy/i_de/i_hsync/i_vsync to corresponding outputs is exactly 3 cycles, fixed, independent of write activity.
- Write latency:
  - Cursor outputs update 1 cycle after acceptance.
  - A RAM write is visible to a pixel read issued at least 1 cycle later.
  - A same-cycle collision returns the old data.
- Reset mid-clear or mid-write: any in-progress operation is abandoned; clear restarts from address 0 after deassertion.
- i_wr_valid during CLEAR is not accepted and the byte is held by the source; no byte is dropped or duplicated.

## Test plan
- Reset, then wait: o_wr_ready=0 for 7200 cycles, then 1. A sweep over all cells reads o_character=0x20 and the cursor is 0,0.
- Write "A" (0x41), then scan raster (0,0): o_character=0x41 three cycles after sx=0,sy=0, with o_glyph_x=0 and o_glyph_y=0. Cursor is 1,0.
- Write 160 x 0x41: cursor goes to 0,1. Then write 0x0A at row 44: row wraps to 0 and column goes to 0.
- Write 0x42, 0x08, 0x08 at cursor 0,0: cursor ends at 0,0, with the second backspace doing nothing. Then write 0x0D and 0x07: cursor is unchanged and the RAM is unchanged.
- Drive sx=1280 (outside the 160*8 text area) and sy=720: o_en=0 and o_character=0x20. o_de/o_hsync/o_vsync match the inputs delayed 3 cycles.
- Write 0x0C mid-frame while holding i_wr_valid with 0x43: o_wr_ready drops for 7200 cycles and 0x43 is accepted afterward at 0,0. Assert i_rst_n=0 at clear cycle 100: outputs go to their reset values immediately and the clear restarts from address 0.
